// File: rtl/ttt_event_scheduler_if.sv
// Network-side handshake of the event scheduler: one-beat issue
// (valid / source id / start-stop code) plus the network's done strobe.
interface ttt_event_scheduler_if #(
    parameter int NUM_PROCESSORS = 10
);
    localparam int ID_W = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1;

    logic            net_valid_in;
    logic [ID_W-1:0] net_source_id;
    logic [1:0]      net_token_startstop;
    logic            net_done;

    // Scheduler side: drives the issue beat, receives done
    modport master (
        output net_valid_in,
        output net_source_id,
        output net_token_startstop,
        input  net_done
    );

    // Network side: receives the issue beat, returns done
    modport slave (
        input  net_valid_in,
        input  net_source_id,
        input  net_token_startstop,
        output net_done
    );
endinterface

// File: rtl/ttt_event_scheduler.sv
// Event scheduler: captures per-processor start/stop event codes into a
// pending table, arbitrates one pending event at a time onto the network
// and waits for done (or a watchdog expiry) before issuing the next.
// Optional build macro TTT_SCHED_FIXED_PRIO_EN: lowest pending index always
// wins and no round-robin pointer exists; when undefined the arbiter is
// round-robin starting after the last granted index.
module ttt_event_scheduler #(
    parameter int NUM_PROCESSORS = 10,
    parameter int MAX_WAIT       = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [NUM_PROCESSORS-1:0]   evt_valid,
    input  logic [2*NUM_PROCESSORS-1:0] evt_code,
    input  logic                        overflow_clr,
    ttt_event_scheduler_if.master       net,
    output logic [NUM_PROCESSORS-1:0]   pending,
    output logic                        busy,
    output logic                        overflow,
    output logic                        timeout
);
    localparam int ID_W = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1;
    // Watchdog gives up once the incremented count reaches MAX_WAIT-1
    localparam logic [16:0] WD_LIMIT = 17'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                    state_q;
    logic                      valid_q;
    logic [ID_W-1:0]           src_id_q;
    logic [1:0]                tok_q;
    logic                      timeout_q;
    logic [15:0]               wd_q;
    logic [16:0]               wd_inc;
    logic                      overflow_q;
    logic [NUM_PROCESSORS-1:0] pending_q;
    logic [NUM_PROCESSORS-1:0] pending_d;
    logic [NUM_PROCESSORS-1:0] cap;
    logic [NUM_PROCESSORS-1:0] clr;
    logic [NUM_PROCESSORS-1:0] ovf_hit;
    logic [1:0]                code_q [NUM_PROCESSORS];
    logic                      grant_found;
    logic [ID_W-1:0]           grant_idx;
    logic                      grant_fire;

`ifdef TTT_SCHED_FIXED_PRIO_EN
    // Fixed priority: lowest pending index wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_PROCESSORS; k++) begin
            if (!grant_found && pending_q[ID_W'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr_q;

    // Round robin: first pending index strictly after the last grant, with wrap
    always_comb begin
        int idx_int;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_int     = 0;
        for (int k = 1; k <= NUM_PROCESSORS; k++) begin
            idx_int = (int'(rr_ptr_q) + k) % NUM_PROCESSORS;
            if (!grant_found && pending_q[ID_W'(idx_int)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx_int);
            end
        end
    end

    // Remember the last granted index; reset value makes processor 0 win first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= ID_W'(NUM_PROCESSORS - 1);
        end else if (grant_fire) begin
            rr_ptr_q <= grant_idx;
        end
    end
`endif

    assign grant_fire = (state_q == S_IDLE) && enable && grant_found;
    assign wd_inc     = {1'b0, wd_q} + 17'd1;

    // Per-processor capture: a new event beats a same-cycle grant clear,
    // and only overwriting a still-pending entry counts as overflow
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_slot
            assign cap[gi]       = evt_valid[gi] && (evt_code[2*gi +: 2] != 2'b00);
            assign clr[gi]       = grant_fire && (grant_idx == ID_W'(gi));
            assign ovf_hit[gi]   = cap[gi] && pending_q[gi] && !clr[gi];
            assign pending_d[gi] = cap[gi] | (pending_q[gi] & ~clr[gi]);

            // Stored code for this processor, updated on every accepted event
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    code_q[gi] <= 2'b00;
                end else if (cap[gi]) begin
                    code_q[gi] <= evt_code[2*gi +: 2];
                end
            end
        end
    endgenerate

    // Pending-table occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Sticky overflow; a new overwrite wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (|ovf_hit) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // Issue FSM with registered issue beat, held id/code and watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            src_id_q  <= '0;
            tok_q     <= 2'b00;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_fire) begin
                        state_q  <= S_ISSUE;
                        valid_q  <= 1'b1;
                        src_id_q <= grant_idx;
                        tok_q    <= code_q[grant_idx];
                    end
                end
                S_ISSUE: begin
                    valid_q <= 1'b0;
                    wd_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (net.net_done) begin
                        state_q <= S_IDLE;
                    end else begin
                        wd_q <= wd_inc[15:0];
                        if (wd_inc >= WD_LIMIT) begin
                            timeout_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign net.net_valid_in        = valid_q;
    assign net.net_source_id       = src_id_q;
    assign net.net_token_startstop = tok_q;
    assign pending                 = pending_q;
    assign busy                    = (state_q != S_IDLE);
    assign overflow                = overflow_q;
    assign timeout                 = timeout_q;
endmodule

// File: tb/tb_ttt_event_scheduler.sv
// Directed bench for ttt_event_scheduler: expected issues are queued when
// events are posted and checked by a monitor as the DUT issues them.
module tb_ttt_event_scheduler;
    localparam int N = 10;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           enable;
    logic [N-1:0]   evt_valid;
    logic [2*N-1:0] evt_code;
    logic           overflow_clr;
    logic [N-1:0]   pending;
    logic           busy, overflow, timeout;
    logic           auto_done = 1'b0;
    logic           man_done  = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_issue = -100;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] code;
    } exp_t;
    exp_t sb[$];

    ttt_event_scheduler_if #(.NUM_PROCESSORS(N)) net_if ();

    ttt_event_scheduler #(.NUM_PROCESSORS(N), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .overflow_clr (overflow_clr),
        .net          (net_if),
        .pending      (pending),
        .busy         (busy),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int id, input logic [1:0] code);
        evt_valid[id]        = 1'b1;
        evt_code[2*id +: 2]  = code;
    endtask

    task automatic push(input int id, input logic [1:0] code);
        exp_t e;
        e.id   = 4'(id);
        e.code = code;
        sb.push_back(e);
    endtask

    task automatic wait_issue(input int id, input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (net_if.net_valid_in === 1'b1 && net_if.net_source_id == 4'(id)) begin
                found = 1'b1;
                break;
            end
        end
        chk($sformatf("wait_issue_id%0d", id), {31'd0, found}, 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0) break;
        end
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Done responder: auto mode answers one cycle after each issue beat,
    // manual mode follows man_done (changed by the main sequence at negedges)
    initial begin
        logic auto_hit;
        net_if.net_done = 1'b0;
        forever begin
            @(negedge clk);
            auto_hit = auto_done && (net_if.net_valid_in === 1'b1);
            @(posedge clk);
            #1;
            net_if.net_done = auto_hit | man_done;
        end
    end

    // Monitor: every issue beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (net_if.net_valid_in === 1'b1) begin
            exp_t e;
            $display("issue t=%0d id=%0d code=%0d", cyc, net_if.net_source_id, net_if.net_token_startstop);
            chk("issue_gap_ge3", {31'd0, (cyc - last_issue) >= 3}, 32'd1);
            last_issue = cyc;
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_issue observed=id%0d expected=no_issue", net_if.net_source_id);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("issue_id", {28'd0, net_if.net_source_id}, {28'd0, e.id});
                chk("issue_code", {30'd0, net_if.net_token_startstop}, {30'd0, e.code});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k_pos, k_cnt;
        reset_n      = 1'b0;
        enable       = 1'b1;
        overflow_clr = 1'b0;
        evt_valid    = '1;
        evt_code     = '0;
        for (int i = 0; i < N; i++) evt_code[2*i +: 2] = 2'((i % 3) + 1);

        // Reset with all strobes held: nothing captured, nothing issued
        repeat (3) begin
            @(negedge clk);
            chk("rst_pending", {22'd0, pending}, 32'd0);
            chk("rst_valid", {31'd0, net_if.net_valid_in}, 32'd0);
        end
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_id", {28'd0, net_if.net_source_id}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) push(i, 2'((i % 3) + 1));
        auto_done = 1'b1;
        tick();
        evt_valid = '0;
        @(negedge clk);
        chk("capture_all", {22'd0, pending}, 32'h3FF);
        wait_drain("all_ten", 200);

        // Single event latency; done during ISSUE is ignored
        auto_done = 1'b0;
        tick();
        post(3, 2'b01);
        push(3, 2'b01);
        tick();
        evt_valid = '0;
        @(negedge clk);
        chk("lat_t1_valid", {31'd0, net_if.net_valid_in}, 32'd0);
        man_done = 1'b1;
        @(negedge clk);
        chk("lat_t2_valid", {31'd0, net_if.net_valid_in}, 32'd1);
        chk("lat_t2_id", {28'd0, net_if.net_source_id}, 32'd3);
        man_done = 1'b0;
        @(negedge clk);
        chk("done_in_issue_ignored", {31'd0, busy}, 32'd1);
        chk("id_held", {28'd0, net_if.net_source_id}, 32'd3);
        man_done = 1'b1;
        @(negedge clk);
        chk("busy_wait", {31'd0, busy}, 32'd1);
        man_done = 1'b0;
        @(negedge clk);
        chk("busy_falls", {31'd0, busy}, 32'd0);

        // Arbitration order from a fresh reset with re-posts
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        enable  = 1'b0;
        post(2, 2'b01);
        post(5, 2'b10);
        post(7, 2'b11);
`ifdef TTT_SCHED_FIXED_PRIO_EN
        push(2, 2'b01); push(2, 2'b01); push(5, 2'b10); push(5, 2'b10); push(7, 2'b11);
`else
        push(2, 2'b01); push(5, 2'b10); push(7, 2'b11); push(2, 2'b01); push(5, 2'b10);
`endif
        tick();
        evt_valid = '0;
        enable    = 1'b1;
        auto_done = 1'b1;
        wait_issue(2, 20);
        tick();
        post(2, 2'b01);
        tick();
        evt_valid = '0;
        wait_issue(5, 30);
        tick();
        post(5, 2'b10);
        tick();
        evt_valid = '0;
        wait_drain("arb", 60);

        // Overflow: overwrite while disabled, clear, then set-wins-over-clear
        enable = 1'b0;
        tick();
        post(4, 2'b01);
        tick();
        evt_valid = '0;
        post(4, 2'b10);
        tick();
        evt_valid = '0;
        @(negedge clk);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_pending4", {31'd0, pending[4]}, 32'd1);
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        tick();
        overflow_clr = 1'b1;
        post(4, 2'b10);
        tick();
        overflow_clr = 1'b0;
        evt_valid    = '0;
        @(negedge clk);
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared2", {31'd0, overflow}, 32'd0);
        push(4, 2'b10);
        enable = 1'b1;
        wait_drain("ovf", 30);

        // Grant clear and new event on the same id in the same cycle
        tick();
        post(6, 2'b01);
        push(6, 2'b01);
        push(6, 2'b10);
        tick();
        evt_valid = '0;
        post(6, 2'b10);
        tick();
        evt_valid = '0;
        @(negedge clk);
        chk("same_cycle_pending6", {31'd0, pending[6]}, 32'd1);
        chk("same_cycle_no_ovf", {31'd0, overflow}, 32'd0);
        wait_drain("same_cycle", 30);

        // Watchdog with MAX_WAIT=8: no done, timeout 8 cycles after ISSUE
        auto_done = 1'b0;
        tick();
        post(1, 2'b01);
        post(8, 2'b11);
`ifdef TTT_SCHED_FIXED_PRIO_EN
        push(1, 2'b01); push(8, 2'b11);
`else
        push(8, 2'b11); push(1, 2'b01);
`endif
        tick();
        evt_valid = '0;
`ifdef TTT_SCHED_FIXED_PRIO_EN
        wait_issue(1, 10);
`else
        wait_issue(8, 10);
`endif
        k_pos = 0;
        k_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                k_cnt++;
                k_pos = i;
            end
        end
        chk("wd_pulse_count", k_cnt, 1);
        chk("wd_pulse_pos", k_pos, 8);
        chk("wd_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("wd_pulse_ends", {31'd0, timeout}, 32'd0);
        chk("wd_next_issue", {31'd0, net_if.net_valid_in}, 32'd1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        wait_drain("wd", 20);

        // Async reset in WAIT: outputs clear without a clock edge
        tick();
        post(0, 2'b11);
        push(0, 2'b11);
        tick();
        evt_valid = '0;
        wait_issue(0, 10);
        tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_id", {28'd0, net_if.net_source_id}, 32'd0);
        chk("async_code", {30'd0, net_if.net_token_startstop}, 32'd0);
        chk("async_valid", {31'd0, net_if.net_valid_in}, 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_done_busy", {31'd0, busy}, 32'd0);
        chk("late_done_timeout", {31'd0, timeout}, 32'd0);
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ttt_event_scheduler.md
Name: ttt_event_scheduler

Overview:
- Sequences token start/stop events from the processor array into the connection network, one event at a time.
- Each processor can post one event code. Events are held in a pending table.
- A round-robin arbiter picks one pending event and issues it to the network as a single-cycle valid_in / source_id / token_startstop beat. It then waits for the network's done before issuing the next.
- A watchdog recovers the scheduler if done never arrives.

Parameters:
- NUM_PROCESSORS, 10, number of event sources; ID width is $clog2(NUM_PROCESSORS).
- MAX_WAIT, 255, cycles to wait in WAIT for net_done before timeout; range 1..65535.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  when high, new issues are permitted
- evt_valid  input  NUM_PROCESSORS  per-processor event strobe
- evt_code  input  2*NUM_PROCESSORS  2-bit start/stop code per processor; processor i uses bits [2i+1:2i]
- overflow_clr  input  1  clears overflow
- net_valid_in  output  1  issue strobe to network
- net_source_id  output  $clog2(NUM_PROCESSORS)  issued processor ID
- net_token_startstop  output  2  issued code
- net_done  input  1  network finished current event
- pending  output  NUM_PROCESSORS  pending-table occupancy
- busy  output  1  high in ISSUE or WAIT
- overflow  output  1  sticky: a pending event was overwritten
- timeout  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async assert): state=IDLE; pending=0; stored codes=0; net_valid_in=0; net_source_id=0; net_token_startstop=0; busy=0; overflow=0; timeout=0; watchdog=0; RR pointer=NUM_PROCESSORS-1, so processor 0 wins first. Deassertion is synchronous to clk.
- Capture: evt_valid[i]=1 with code!=2'b00 → pending[i]=1 and code stored at the clock edge.
  - Code 2'b00 is ignored.
  - If pending[i] is already 1 and not being cleared in that same cycle: new code overwrites and overflow is set.
- overflow_clr: clears overflow. If it coincides with a new overflow event, set wins.
- FSM (three states):
  - IDLE: if enable and pending!=0, grant = first set bit searching upward from RR pointer+1 with wrap. Register net_source_id=grant and net_token_startstop=code[grant]; clear pending[grant]; RR pointer=grant; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: net_valid_in=1 for exactly this one cycle; watchdog=0; go to WAIT.
  - WAIT: net_valid_in=0. On net_done=1, go to IDLE. Otherwise watchdog++; when watchdog reaches MAX_WAIT-1 without done, pulse timeout for one cycle and go to IDLE.
- Same-cycle grant clear and new evt_valid on the same ID: the new event stays pending; no overflow.
- Latency: evt_valid in cycle t with the scheduler idle → net_valid_in high in cycle t+2. Back-to-back issues are at least 3 cycles apart (ISSUE, WAIT≥1, IDLE).
- net_done outside WAIT, including during ISSUE, is ignored.
- net_source_id and net_token_startstop hold their last values until the next grant.
- enable low: no new grant. An issue already in flight completes. Capture continues.
- busy = (state!=IDLE), decoded from registered state.
- Reset mid-WAIT: everything returns to reset values immediately; the in-flight event is dropped.

Optional Feature:
- Macro TTT_SCHED_FIXED_PRIO_EN.
- Defined: the arbiter is fixed-priority; the lowest pending index always wins, and the RR pointer is not implemented.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with evt_valid=10'h3FF held → pending=0, net_valid_in=0 throughout reset; after release, pending=10'h3FF next cycle and first issue has net_source_id=0.
- Single event: evt_valid[3]=1, code 2'b01 in cycle 5 → net_valid_in=1 in cycle 7 with id=3, code=01; net_done in cycle 9 → busy falls in cycle 10.
- Round robin: pending={2,5,7}, done returned 1 cycle after each issue → issue order 2,5,7. Re-post 2 and 5 after the first grant → order 2,5,7,2,5. With TTT_SCHED_FIXED_PRIO_EN: 2,2,5,5,7.
- Overflow: post id 4 code 01, then id 4 code 10 while enable=0 → overflow=1, later issue carries code 10. overflow_clr → overflow=0.
- Watchdog with MAX_WAIT=8: never assert net_done → timeout pulses exactly once, 8 cycles after ISSUE; FSM returns to IDLE and issues the next pending event.
- Async reset asserted mid-WAIT → outputs zero in the same cycle without a clock edge; a late net_done after release has no effect.
